// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU definitions for the fetch stage and later pipeline
// registers: opcode field position, HALT opcode, fetch FSM encodings, NOP word.
package fetch_stage_pkg;
  localparam int         OPCODE_MSB = 15;
  localparam int         OPCODE_LSB = 12;
  localparam logic [3:0] HALT_OP    = 4'hF;

  // Fetch FSM encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] FS_BOOT    = 2'd0;
  localparam logic [1:0] FS_RUN     = 2'd1;
  localparam logic [1:0] FS_HALTED  = 2'd2;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the instruction-memory bus, the hazard/branch control
// inputs and the IF/ID register outputs of the fetch stage.
//   master : the fetch stage (drives imem_addr/en/wr, if_id_*, halted)
//   slave  : memory + downstream pipeline (drives imem_data, stall, redirect*)
interface fetch_stage_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
);
  logic [AWIDTH-1:0] imem_addr;
  logic              imem_en;
  logic              imem_wr;
  logic [DWIDTH-1:0] imem_data;
  logic              stall;
  logic              redirect;
  logic [AWIDTH-1:0] redirect_target;
  logic [DWIDTH-1:0] if_id_instr;
  logic [AWIDTH-1:0] if_id_pc;
  logic [AWIDTH-1:0] if_id_pc_plus2;
  logic              if_id_valid;
  logic              halted;

  modport master (
    output imem_addr, imem_en, imem_wr,
    output if_id_instr, if_id_pc, if_id_pc_plus2, if_id_valid, halted,
    input  imem_data, stall, redirect, redirect_target
  );

  modport slave (
    input  imem_addr, imem_en, imem_wr,
    input  if_id_instr, if_id_pc, if_id_pc_plus2, if_id_valid, halted,
    output imem_data, stall, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg: generic pipeline register with async reset.
//   ld      : capture d and set valid
//   clr_vld : drop valid, keep payload (wins over ld)
//   neither : hold everything (stall)
// Ports: clk, rst, ld, clr_vld, d[W], q[W], vld
module fetch_stage_if_id_reg #(
  parameter int           W       = 48,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr_vld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);
  logic [W-1:0] data_d, data_q;
  logic         vld_d, vld_q;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_vld) begin
      vld_d = 1'b0;
    end else if (ld) begin
      data_d = d;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q   = data_q;
  assign vld = vld_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch. Holds the PC, reads the combinational
// instruction memory at pc and registers {instr, pc, pc+2} into IF/ID.
// Priority per edge: redirect > stall > normal. A fetched HALT freezes the PC
// and stops fetch until a redirect arrives.
// Ports: clk, rst (async, active high), bus (fetch_stage_if.master).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              AWIDTH      = 16,
  parameter int              DWIDTH      = 16,
  parameter logic [AWIDTH-1:0] RESET_PC  = '0,
  parameter logic [3:0]      HALT_OPCODE = HALT_OP
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int RW = DWIDTH + 2*AWIDTH;

  logic [1:0]        state_d, state_q;
  logic [AWIDTH-1:0] pc_d, pc_q;
  logic              halted_d, halted_q;
  logic              ld, clr_vld;
  logic [AWIDTH-1:0] pc_plus2;
  logic              is_halt;
  logic [RW-1:0]     reg_d, reg_q;
  logic              unused_tgt0;

  assign pc_plus2    = pc_q + AWIDTH'(2);
  assign is_halt     = bus.imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  assign unused_tgt0 = bus.redirect_target[0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ld      = 1'b0;
    clr_vld = 1'b0;
    if (bus.redirect) begin
      // squash: also lifts a HALT fetched down the wrong path
      pc_d    = {bus.redirect_target[AWIDTH-1:1], 1'b0};
      clr_vld = 1'b1;
      state_d = FS_RUN;
    end else if (state_q == FS_BOOT) begin
      // boot cycle only lets the memory image settle; leaves regardless of stall
      state_d = FS_RUN;
    end else if (!bus.stall) begin
      case (state_q)
        FS_RUN: begin
          ld = 1'b1;
          if (is_halt) state_d = FS_HALTED;
          else         pc_d    = pc_plus2;
        end
        FS_HALTED: clr_vld = 1'b1;
        default:   state_d = FS_BOOT;
      endcase
    end
    halted_d = (state_d == FS_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FS_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign reg_d = {bus.imem_data, pc_q, pc_plus2};

  fetch_stage_if_id_reg #(
    .W       (RW),
    .RST_VAL ({DWIDTH'(NOP_INSTR), {(2*AWIDTH){1'b0}}})
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .clr_vld (clr_vld),
    .d       (reg_d),
    .q       (reg_q),
    .vld     (bus.if_id_valid)
  );

  assign bus.if_id_instr    = reg_q[RW-1 -: DWIDTH];
  assign bus.if_id_pc       = reg_q[2*AWIDTH-1 -: AWIDTH];
  assign bus.if_id_pc_plus2 = reg_q[AWIDTH-1:0];
  assign bus.halted         = halted_q;
  assign bus.imem_addr      = pc_q;
  assign bus.imem_en        = (state_q == FS_RUN);
  assign bus.imem_wr        = 1'b0;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic clk, rst;
  int   checks, errors;

  fetch_stage_if #(.AWIDTH(16), .DWIDTH(16)) bus ();
  fetch_stage #(.AWIDTH(16), .DWIDTH(16), .RESET_PC(16'h0000), .HALT_OPCODE(4'hF))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] mem [0:32767];
  assign bus.imem_data = mem[bus.imem_addr[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: what the fetch stage should be showing
  int          m_pc;
  bit          m_boot, m_halt, m_valid;
  logic [15:0] m_instr, m_ipc, m_ipc2;

  typedef struct {
    logic s, r; logic [15:0] t;
    logic [15:0] pc; logic v; logic [15:0] ins, ipc, ipc2; logic h, en;
  } vec_t;
  vec_t vt [18];

  function automatic logic [67:0] dut_bundle();
    return {bus.imem_addr, bus.imem_en, bus.imem_wr, bus.if_id_valid,
            bus.if_id_instr, bus.if_id_pc, bus.if_id_pc_plus2, bus.halted};
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_boot = 1; m_halt = 0; m_valid = 0;
    m_instr = 0; m_ipc = 0; m_ipc2 = 0;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic [15:0] t);
    logic [15:0] w;
    if (r) begin
      m_pc = t & 16'hFFFE; m_valid = 0; m_boot = 0; m_halt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (s) begin
      // everything holds
    end else if (m_halt) begin
      m_valid = 0;
    end else begin
      w = mem[m_pc / 2];
      m_instr = w; m_ipc = 16'(m_pc); m_ipc2 = 16'((m_pc + 2) % 65536); m_valid = 1;
      if (w[15:12] == 4'hF) m_halt = 1;
      else m_pc = (m_pc + 2) % 65536;
    end
  endtask

  function automatic logic [67:0] model_bundle();
    return {16'(m_pc), !m_boot && !m_halt, 1'b0, m_valid, m_instr, m_ipc, m_ipc2, m_halt};
  endfunction

  task automatic step(input logic s, input logic r, input logic [15:0] t);
    bus.stall = s; bus.redirect = r; bus.redirect_target = t;
    model_edge(s, r, t);
    @(posedge clk); #1;
    check("model", dut_bundle(), model_bundle());
  endtask

  initial begin
    checks = 0; errors = 0;
    bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;

    //        s r target    pc       v ins      ipc      ipc2     h en
    vt[0]  = '{0,0,16'h0000,16'h0000,0,16'h0000,16'h0000,16'h0000,0,1};
    vt[1]  = '{0,0,16'h0000,16'h0002,1,16'h1111,16'h0000,16'h0002,0,1};
    vt[2]  = '{0,0,16'h0000,16'h0004,1,16'h2222,16'h0002,16'h0004,0,1};
    vt[3]  = '{1,0,16'h0000,16'h0004,1,16'h2222,16'h0002,16'h0004,0,1};
    vt[4]  = '{1,0,16'h0000,16'h0004,1,16'h2222,16'h0002,16'h0004,0,1};
    vt[5]  = '{1,0,16'h0000,16'h0004,1,16'h2222,16'h0002,16'h0004,0,1};
    vt[6]  = '{0,0,16'h0000,16'h0006,1,16'h3333,16'h0004,16'h0006,0,1};
    vt[7]  = '{1,1,16'h0041,16'h0040,0,16'h3333,16'h0004,16'h0006,0,1};
    vt[8]  = '{0,0,16'h0000,16'h0042,1,16'h1020,16'h0040,16'h0042,0,1};
    vt[9]  = '{0,1,16'h0004,16'h0004,0,16'h1020,16'h0040,16'h0042,0,1};
    vt[10] = '{0,0,16'h0000,16'h0006,1,16'h3333,16'h0004,16'h0006,0,1};
    vt[11] = '{0,0,16'h0000,16'h0006,1,16'hF000,16'h0006,16'h0008,1,0};
    vt[12] = '{0,0,16'h0000,16'h0006,0,16'hF000,16'h0006,16'h0008,1,0};
    vt[13] = '{1,0,16'h0000,16'h0006,0,16'hF000,16'h0006,16'h0008,1,0};
    vt[14] = '{0,1,16'h0010,16'h0010,0,16'hF000,16'h0006,16'h0008,0,1};
    vt[15] = '{0,0,16'h0000,16'h0012,1,16'h1008,16'h0010,16'h0012,0,1};
    vt[16] = '{0,1,16'hFFFE,16'hFFFE,0,16'h1008,16'h0010,16'h0012,0,1};
    vt[17] = '{0,0,16'h0000,16'h0000,1,16'h7FFF,16'hFFFE,16'h0000,0,1};

    // reset: asserted before any edge, outputs must already be cleared
    rst = 0;
    #1 rst = 1;
    model_reset();
    #1;
    check("reset_state", dut_bundle(), {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0});
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", dut_bundle(), model_bundle());
    rst = 0;

    for (int i = 0; i < 18; i++) begin
      step(vt[i].s, vt[i].r, vt[i].t);
      check($sformatf("vec%0d", i), dut_bundle(),
            {vt[i].pc, vt[i].en, 1'b0, vt[i].v, vt[i].ins, vt[i].ipc, vt[i].ipc2, vt[i].h});
    end

    // async reset mid-cycle must take effect before the next edge
    #2 rst = 1;
    model_reset();
    #1;
    check("async_rst_run", dut_bundle(), {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0});
    @(posedge clk); #1;
    rst = 0;

    // reach HALTED then reset out of it
    step(0, 0, 0);                 // boot edge
    step(0, 1, 16'h0006);
    step(0, 0, 0);                 // HALT at 6
    check("halt_reached", {67'd0, bus.halted}, {67'd0, 1'b1});
    #2 rst = 1;
    model_reset();
    #1;
    check("async_rst_halt", dut_bundle(), {16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0});
    @(posedge clk); #1;
    rst = 0;

    // randomized traffic against the model
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      logic s, r; logic [15:0] t;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      t = $urandom_range(0, 1) ? 16'($urandom_range(0, 63)) : 16'($urandom);
      step(s, r, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
